// File: rtl/dds_spi_pkg.sv
// rtl/dds_spi_pkg.sv - shared SPI frame layout for the DDS transmitter and DAC receiver
package dds_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CTRL_BITS  = 2;
    localparam int CTRL_LSB   = 12;
    localparam int CTRL_MSB   = CTRL_LSB + CTRL_BITS - 1;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_CHECK
    } rx_state_t;

    // Bit counter stops one past a full frame so overlong frames stay distinguishable.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_W'(FRAME_BITS + 1)) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_dac_receiver_if.sv
// rtl/spi_dac_receiver_if.sv - SPI DAC link lines and decoded sample outputs
interface spi_dac_receiver_if;
    import dds_spi_pkg::*;

    logic                 spi_sck;
    logic                 spi_mosi;
    logic                 spi_cs;
    logic [DATA_BITS-1:0] sample_amplitude;
    logic [CTRL_BITS-1:0] sample_ctrl;
    logic                 sample_valid;
    logic                 frame_err;
    logic [15:0]          frame_count;

    modport master (
        output spi_sck, spi_mosi, spi_cs,
        input  sample_amplitude, sample_ctrl, sample_valid, frame_err, frame_count
    );

    modport slave (
        input  spi_sck, spi_mosi, spi_cs,
        output sample_amplitude, sample_ctrl, sample_valid, frame_err, frame_count
    );

endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with history flop for edge pulses
module sync_edge_detect #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{IDLE_LEVEL}};
            hist_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[0], din};
            hist_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~hist_q;
    assign fall  = ~sync_q[1] & hist_q;

endmodule

// File: rtl/spi_dac_receiver.sv
// rtl/spi_dac_receiver.sv - oversampling SPI DAC frame receiver with good/bad frame reporting
module spi_dac_receiver
    import dds_spi_pkg::*;
#(
    parameter bit SAMPLE_EDGE = 1'b1
) (
    input  logic               sysclk,
    input  logic               reset_n,
    spi_dac_receiver_if.slave  bus
);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    sync_edge_detect #(.IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk   (sysclk),
        .rst_n (reset_n),
        .din   (bus.spi_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge_detect #(.IDLE_LEVEL(1'b0)) u_sync_sck (
        .clk   (sysclk),
        .rst_n (reset_n),
        .din   (bus.spi_sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge_detect #(.IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk   (sysclk),
        .rst_n (reset_n),
        .din   (bus.spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic sck_edge;
    assign sck_edge = SAMPLE_EDGE ? sck_fall : sck_rise;

    // The cs synchroniser resets to idle-high, so a cs already low at reset release
    // shows up as a falling edge; frames are only accepted once cs has been seen high
    // after the synchroniser has flushed its reset value.
    logic [1:0] settle_q;
    logic       armed_q;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd3 && cs_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    rx_state_t state_q, state_d;
    logic      shift_clr;
    logic      shift_en;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_clr = 1'b0;
        shift_en  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = RX_SHIFT;
                    shift_clr = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (cs_rise) begin
                    state_d = RX_CHECK;
                end else if (sck_edge) begin
                    shift_en = 1'b1;
                end
            end
            RX_CHECK: begin
                if (cs_fall) begin
                    state_d   = RX_SHIFT;
                    shift_clr = 1'b1;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (shift_clr) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (shift_en) begin
            shreg_q   <= {shreg_q[FRAME_BITS-2:0], mosi_level};
            bit_cnt_q <= cnt_sat_inc(bit_cnt_q);
        end
    end

    logic                 frame_good;
    logic [DATA_BITS-1:0] amp_q;
    logic [CTRL_BITS-1:0] ctrl_q;
    logic                 valid_q;
    logic                 err_q;
    logic [15:0]          frame_cnt_q;

    assign frame_good = (bit_cnt_q == CNT_W'(FRAME_BITS));

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            amp_q       <= '0;
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_q == RX_CHECK) begin
                if (frame_good) begin
                    amp_q       <= shreg_q[DATA_BITS-1:0];
                    ctrl_q      <= shreg_q[CTRL_MSB:CTRL_LSB];
                    valid_q     <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sample_amplitude = amp_q;
    assign bus.sample_ctrl      = ctrl_q;
    assign bus.sample_valid     = valid_q;
    assign bus.frame_err        = err_q;
    assign bus.frame_count      = frame_cnt_q;

    logic unused_sigs;
    assign unused_sigs = ^{mosi_rise, mosi_fall, sck_level, shreg_q[FRAME_BITS-1:CTRL_MSB+1]};

endmodule
